// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word and branch target buffer entry layout.
// Counter encodings for the 2-bit taken/not-taken predictors.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int BTB_ENTRIES = 16;
  // Widest tag any legal geometry needs; narrower tags use low bits.
  localparam int BTB_TAG_MAX = 30;

  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_WNT = 2'b01;

  typedef struct packed {
    logic                   valid;
    logic [BTB_TAG_MAX-1:0] tag;
    word_t                  target;
    logic [1:0]             ctr;
  } btb_entry_t;

  localparam btb_entry_t BTB_RST = '{
    valid:  1'b0,
    tag:    '0,
    target: '0,
    ctr:    CTR_WNT
  };

  function automatic word_t pc_plus4(input word_t pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// Next-state logic of a 2-bit saturating up/down counter.
// Holds when neither or both enables are set.
module sat_counter2 (
  input  logic [1:0] ctr_i,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    unique case (1'b1)
      inc_i && !dec_i: begin
        if (ctr_i != 2'b11) ctr_o = ctr_i + 2'b01;
      end
      dec_i && !inc_i: begin
        if (ctr_i != 2'b00) ctr_o = ctr_i - 2'b01;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/btb_branch_ctrl.sv
// Direct-mapped BTB with 2-bit counters, mispredict detection,
// pipeline flush/redirect and a saturating mispredict counter.
module btb_branch_ctrl
  import cpu_types_pkg::*;
#(
  parameter int ENTRIES = BTB_ENTRIES,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = 30 - IDX_W
) (
  input  logic  CLK,
  input  logic  nRST,
  input  word_t fetch_pc,
  output logic  pred_taken,
  output word_t pred_target,
  input  logic  res_valid,
  input  word_t res_pc,
  input  logic  res_taken,
  input  word_t res_target,
  input  logic  res_pred_taken,
  input  word_t res_pred_target,
  output logic  redirect_en,
  output word_t redirect_pc,
  output logic  flushFD,
  output logic  flushDE,
  output logic  flushEM,
  output word_t mispredict_cnt
);

  btb_entry_t btb_q [ENTRIES];
  word_t      cnt_q;

  logic [IDX_W-1:0] f_idx;
  logic [IDX_W-1:0] r_idx;
  logic [TAG_W-1:0] f_tag;
  logic [TAG_W-1:0] r_tag;
  btb_entry_t       f_ent;
  btb_entry_t       r_ent;
  btb_entry_t       upd_d;
  logic             f_hit;
  logic             r_hit;
  logic             r_alloc;
  logic             upd_we;
  logic             mispredict;
  logic             tgt_wrong;
  logic [1:0]       ctr_nxt;
  logic             unused_bits;

  assign f_idx = fetch_pc[IDX_W+1:2];
  assign f_tag = fetch_pc[31:IDX_W+2];
  assign f_ent = btb_q[f_idx];
  assign f_hit = f_ent.valid
              && (f_ent.tag[TAG_W-1:0] == f_tag);

  // Lookup reads registered state only: no update bypass.
  assign pred_taken  = f_hit && f_ent.ctr[1];
  assign pred_target = pred_taken ? f_ent.target
                                  : pc_plus4(fetch_pc);

  assign tgt_wrong  = res_taken
                   && (res_pred_target != res_target);
  assign mispredict = res_valid
                   && ((res_pred_taken != res_taken)
                    || tgt_wrong);

  assign redirect_en = mispredict;
  assign flushFD     = mispredict;
  assign flushDE     = mispredict;
  assign flushEM     = mispredict;

  always_comb begin
    redirect_pc = '0;
    if (mispredict) begin
      redirect_pc = res_taken ? res_target
                              : pc_plus4(res_pc);
    end
  end

  assign r_idx   = res_pc[IDX_W+1:2];
  assign r_tag   = res_pc[31:IDX_W+2];
  assign r_ent   = btb_q[r_idx];
  assign r_hit   = res_valid && r_ent.valid
                && (r_ent.tag[TAG_W-1:0] == r_tag);
  assign r_alloc = res_valid && res_taken && !r_hit;

  sat_counter2 u_ctr (
    .ctr_i (r_ent.ctr),
    .inc_i (res_taken),
    .dec_i (!res_taken),
    .ctr_o (ctr_nxt)
  );

  always_comb begin
    upd_d  = r_ent;
    upd_we = 1'b0;
    unique case (1'b1)
      r_hit: begin
        upd_we    = 1'b1;
        upd_d.ctr = ctr_nxt;
        if (res_taken) upd_d.target = res_target;
      end
      r_alloc: begin
        upd_we                = 1'b1;
        upd_d.valid           = 1'b1;
        upd_d.tag             = '0;
        upd_d.tag[TAG_W-1:0]  = r_tag;
        upd_d.target          = res_target;
        upd_d.ctr             = CTR_WT;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i] <= BTB_RST;
      end
      cnt_q <= '0;
    end else begin
      if (upd_we) btb_q[r_idx] <= upd_d;
      if (mispredict && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  assign mispredict_cnt = cnt_q;

  assign unused_bits = ^{f_ent.tag[BTB_TAG_MAX-1:TAG_W],
                         r_ent.tag[BTB_TAG_MAX-1:TAG_W],
                         f_ent.ctr[0]};

endmodule
